// File: rtl/dbg_pkg.sv
// ----------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the serial debug unit: ASCII constants used when
// printing, the empty-word marker, and the print-service state encoding.
// No ports; imported by the print_tx slice.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package dbg_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Marks an empty slot; prints as eight 'F' digits.
  localparam logic [31:0] WORD_EMPTY = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } print_state_t;

endpackage

// File: rtl/print_tx_if.sv
// ----------------------------------------------------------------------------
// print_tx_if
// Bundles the print request/acknowledge handshake from the command handlers
// together with the valid/ready byte stream towards the UART transmitter.
//   req_tx/type_tx/din_tx : print request, mode and data (requester -> print_tx)
//   ack_tx                : one-cycle completion pulse (print_tx -> requester)
//   tx_data/tx_valid      : byte stream (print_tx -> UART)
//   tx_ready              : UART accepts current byte (UART -> print_tx)
// Modport slave is the print_tx side; master is the environment side.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface print_tx_if;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] din_tx;
  logic        ack_tx;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  req_tx, type_tx, din_tx, tx_ready,
    output ack_tx, tx_data, tx_valid
  );

  modport master (
    output req_tx, type_tx, din_tx, tx_ready,
    input  ack_tx, tx_data, tx_valid
  );
endinterface

// File: rtl/print_tx_nib2ascii.sv
// ----------------------------------------------------------------------------
// nib2ascii
// Combinational nibble-to-ASCII hex digit converter.
//   nib   in  4  nibble value 0..15
//   ascii out 8  '0'..'9', then 'A'..'F' (or 'a'..'f' when LOWER_HEX=1)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module nib2ascii
  import dbg_pkg::*;
#(
  parameter bit LOWER_HEX = 1'b0
) (
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  localparam logic [7:0] LETTER_BASE = LOWER_HEX ? ASCII_A_LO : ASCII_A_UP;

  always_comb begin
    ascii = ASCII_0;
    if (nib < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nib};
    end else begin
      ascii = LETTER_BASE + {4'h0, nib} - 8'd10;
    end
  end

endmodule

// File: rtl/print_tx.sv
// ----------------------------------------------------------------------------
// print_tx
// Serialises a print request (32-bit word as 8 hex digits plus optional
// trailing space, or a single raw character) onto a valid/ready byte stream,
// then pulses ack_tx for one cycle.
//   clk  in  clock
//   rstn in  asynchronous active-low reset
//   bus  print_tx_if.slave (request handshake + byte stream)
// Parameters: LOWER_HEX selects lowercase hex letters, TRAIL_SPACE appends
// a space after a word print.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module print_tx
  import dbg_pkg::*;
#(
  parameter bit LOWER_HEX   = 1'b0,
  parameter bit TRAIL_SPACE = 1'b1
) (
  input  logic      clk,
  input  logic      rstn,
  print_tx_if.slave bus
);

  print_state_t state;
  logic [31:0]  word_q;
  logic         type_q;
  logic [3:0]   idx;
  logic [7:0]   tx_data_q;
  logic         tx_valid_q;
  logic         ack_q;

  logic [31:0]  src_word;
  logic         src_type;
  logic [3:0]   src_idx;
  logic [3:0]   src_nib;
  logic [7:0]   nib_ascii;
  logic [7:0]   next_byte;
  logic [3:0]   last_idx;

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.ack_tx   = ack_q;

  assign last_idx = type_q ? (TRAIL_SPACE ? 4'd8 : 4'd7) : 4'd0;

  // The byte registered at the next edge: in IDLE it is byte 0 of the
  // incoming request (so the first byte is valid one cycle after the
  // request is sampled); in SEND it is the byte after the current one.
  always_comb begin
    src_word = word_q;
    src_type = type_q;
    src_idx  = idx + 4'd1;
    if (state == IDLE) begin
      src_word = bus.din_tx;
      src_type = bus.type_tx;
      src_idx  = 4'd0;
    end
  end

  // Most significant nibble first.
  always_comb begin
    src_nib = src_word[31:28];
    case (src_idx[2:0])
      3'd0: src_nib = src_word[31:28];
      3'd1: src_nib = src_word[27:24];
      3'd2: src_nib = src_word[23:20];
      3'd3: src_nib = src_word[19:16];
      3'd4: src_nib = src_word[15:12];
      3'd5: src_nib = src_word[11:8];
      3'd6: src_nib = src_word[7:4];
      3'd7: src_nib = src_word[3:0];
      default: src_nib = src_word[31:28];
    endcase
  end

  nib2ascii #(.LOWER_HEX(LOWER_HEX)) u_nib2ascii (
    .nib   (src_nib),
    .ascii (nib_ascii)
  );

  always_comb begin
    next_byte = src_word[7:0];
    if (src_type) begin
      next_byte = src_idx[3] ? ASCII_SP : nib_ascii;
    end
  end

  // Print FSM; all stream and ack outputs are registered here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      word_q     <= 32'h0;
      type_q     <= 1'b0;
      idx        <= 4'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_tx) begin
            word_q     <= bus.din_tx;
            type_q     <= bus.type_tx;
            idx        <= 4'd0;
            tx_data_q  <= next_byte;
            tx_valid_q <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_ready) begin
            if (idx == last_idx) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= 8'h00;
              ack_q      <= 1'b1;
              state      <= ACK;
            end else begin
              idx       <= idx + 4'd1;
              tx_data_q <= next_byte;
            end
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_print_tx.sv
// ----------------------------------------------------------------------------
// tb_print_tx
// Drives two print_tx instances (uppercase defaults, and LOWER_HEX=1) with
// the same request stream and checks every emitted byte, every ack and the
// request-to-ack latency against a queue-based model of the print rules.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_print_tx;
  import dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        typ;
  logic [31:0] din;
  logic        rdy;

  always #5 clk = ~clk;

  print_tx_if bus_up ();
  print_tx_if bus_lo ();

  assign bus_up.req_tx   = req;
  assign bus_up.type_tx  = typ;
  assign bus_up.din_tx   = din;
  assign bus_up.tx_ready = rdy;
  assign bus_lo.req_tx   = req;
  assign bus_lo.type_tx  = typ;
  assign bus_lo.din_tx   = din;
  assign bus_lo.tx_ready = rdy;

  print_tx dut_up (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_up)
  );

  print_tx #(.LOWER_HEX(1'b1), .TRAIL_SPACE(1'b1)) dut_lo (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_lo)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_up[$];
  logic [7:0] exp_lo[$];
  logic [7:0] got_up[$];
  logic [7:0] got_lo[$];
  int         pending[2];
  int         acks[2];
  int         exp_acks;
  logic       ack_prev[2];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Model: ASCII hex digit for a nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  // Model: ack cycle (relative to the sampling edge) given the ready pattern.
  function automatic int exp_latency(input int n, input logic [3:0] pat);
    int acc = 0;
    for (int i = 1; i < 1000; i++) begin
      if (pat[(i - 1) % 4]) acc++;
      if (acc == n) return i + 1;
    end
    return -1;
  endfunction

  task automatic push_expected(input logic [31:0] w, input logic t);
    if (t) begin
      for (int i = 0; i < 8; i++) begin
        exp_up.push_back(hex_char(w[31 - 4 * i -: 4], 1'b0));
        exp_lo.push_back(hex_char(w[31 - 4 * i -: 4], 1'b1));
      end
      exp_up.push_back(8'h20);
      exp_lo.push_back(8'h20);
    end else begin
      exp_up.push_back(w[7:0]);
      exp_lo.push_back(w[7:0]);
    end
    pending[0] = 1;
    pending[1] = 1;
    exp_acks++;
  endtask

  task automatic monitor_one(input int d, input logic v, input logic [7:0] data, input logic a);
    int         sz;
    logic [7:0] front;
    sz = (d == 0) ? exp_up.size() : exp_lo.size();
    if (v) begin
      if (sz == 0) begin
        check_output($sformatf("stray_byte_dut%0d", d), {24'h0, data}, 32'h100);
      end else begin
        front = (d == 0) ? exp_up[0] : exp_lo[0];
        check_output($sformatf("byte_dut%0d", d), {24'h0, data}, {24'h0, front});
        if (rdy) begin
          if (d == 0) begin
            void'(exp_up.pop_front());
            got_up.push_back(data);
          end else begin
            void'(exp_lo.pop_front());
            got_lo.push_back(data);
          end
        end
      end
    end
    if (a) begin
      check_output($sformatf("ack_pending_dut%0d", d), pending[d], 1);
      check_output($sformatf("ack_after_bytes_dut%0d", d), sz, 0);
      check_output($sformatf("ack_width_dut%0d", d), {31'h0, ack_prev[d]}, 0);
      pending[d] = 0;
      acks[d]++;
    end
    ack_prev[d] = a;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      monitor_one(0, bus_up.tx_valid, bus_up.tx_data, bus_up.ack_tx);
      monitor_one(1, bus_lo.tx_valid, bus_lo.tx_data, bus_lo.ack_tx);
    end
  end

  task automatic check_seq(input string name, input int d, input logic [7:0] ref_q[$]);
    int sz;
    sz = (d == 0) ? got_up.size() : got_lo.size();
    check_output({name, "_len"}, sz, ref_q.size());
    for (int i = 0; i < sz && i < ref_q.size(); i++) begin
      check_output($sformatf("%s_b%0d", name, i),
                   {24'h0, (d == 0) ? got_up[i] : got_lo[i]}, {24'h0, ref_q[i]});
    end
  endtask

  // One request: raised one cycle after entry, held until the ack cycle,
  // dropped the cycle after; optionally dropped early with din scrambled.
  task automatic apply_stimulus(input logic [31:0] w, input logic t, input logic [3:0] pat,
                                input bit drop_early, output int lat);
    int n;
    n = t ? 9 : 1;
    @(posedge clk); #1;
    din = w; typ = t; req = 1'b1; rdy = 1'b1;
    push_expected(w, t);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      rdy = pat[(i - 1) % 4];
      if (drop_early && i == 2) begin
        req = 1'b0; din = ~w; typ = ~t;
      end
      @(negedge clk);
      if (bus_up.ack_tx) begin
        lat = i;
        break;
      end
    end
    check_output("ack_latency", lat, exp_latency(n, pat));
    check_output("ack_lo_aligned", {31'h0, bus_lo.ack_tx}, 1);
    @(posedge clk); #1;
    req = 1'b0; typ = 1'b0; rdy = 1'b1;
    @(negedge clk);
    check_output("ack_dropped", {31'h0, bus_up.ack_tx}, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] ref_q[$];

    rstn = 1'b0; req = 1'b0; typ = 1'b0; din = 32'h0; rdy = 1'b1;
    exp_acks = 0;
    pending[0] = 0; pending[1] = 0; acks[0] = 0; acks[1] = 0;
    ack_prev[0] = 1'b0; ack_prev[1] = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_valid_up", {31'h0, bus_up.tx_valid}, 0);
    check_output("rst_ack_up",   {31'h0, bus_up.ack_tx}, 0);
    check_output("rst_data_up",  {24'h0, bus_up.tx_data}, 0);
    check_output("rst_valid_lo", {31'h0, bus_lo.tx_valid}, 0);
    check_output("rst_ack_lo",   {31'h0, bus_lo.ack_tx}, 0);
    check_output("rst_data_lo",  {24'h0, bus_lo.tx_data}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    $display("[TB] word print 0x1234ABCD");
    apply_stimulus(32'h1234ABCD, 1'b1, 4'b1111, 1'b0, lat);
    check_output("word_lat_literal", lat, 10);
    ref_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20};
    check_seq("word_up", 0, ref_q);
    ref_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64, 8'h20};
    check_seq("word_lo", 1, ref_q);
    got_up.delete(); got_lo.delete();

    $display("[TB] empty marker");
    apply_stimulus(WORD_EMPTY, 1'b1, 4'b1111, 1'b0, lat);
    ref_q = '{8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h20};
    check_seq("empty_lo", 1, ref_q);
    ref_q = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h20};
    check_seq("empty_up", 0, ref_q);
    got_up.delete(); got_lo.delete();

    $display("[TB] back-to-back CR LF");
    apply_stimulus({24'h0, ASCII_CR}, 1'b0, 4'b1111, 1'b0, lat);
    check_output("cr_lat_literal", lat, 2);
    apply_stimulus({24'h0, ASCII_LF}, 1'b0, 4'b1111, 1'b0, lat);
    check_output("lf_lat_literal", lat, 2);
    ref_q = '{8'h0D, 8'h0A};
    check_seq("crlf_up", 0, ref_q);
    got_up.delete(); got_lo.delete();

    $display("[TB] backpressure 1,0,0,1 with early req drop");
    apply_stimulus(32'hDEADBEEF, 1'b1, 4'b1001, 1'b1, lat);
    check_output("bp_lat_literal", lat, 18);
    ref_q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h20};
    check_seq("bp_up", 0, ref_q);
    got_up.delete(); got_lo.delete();

    $display("[TB] stale request after ack");
    apply_stimulus(32'h0000_0055, 1'b0, 4'b1111, 1'b0, lat);
    repeat (20) @(negedge clk);
    check_output("stale_acks", acks[0], exp_acks);
    check_output("stale_queue", exp_up.size(), 0);
    got_up.delete(); got_lo.delete();

    $display("[TB] reset mid-transfer");
    @(posedge clk); #1;
    din = 32'h1234ABCD; typ = 1'b1; req = 1'b1; rdy = 1'b1;
    push_expected(din, typ);
    repeat (4) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_output("abort_valid_up", {31'h0, bus_up.tx_valid}, 0);
    check_output("abort_ack_up",   {31'h0, bus_up.ack_tx}, 0);
    check_output("abort_valid_lo", {31'h0, bus_lo.tx_valid}, 0);
    check_output("abort_sent_up",  got_up.size(), 3);
    exp_up.delete(); exp_lo.delete();
    pending[0] = 0; pending[1] = 0; exp_acks--;
    ack_prev[0] = 1'b0; ack_prev[1] = 1'b0;
    req = 1'b0; typ = 1'b0;
    got_up.delete(); got_lo.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    apply_stimulus(32'h0000_0041, 1'b0, 4'b1111, 1'b0, lat);
    ref_q = '{8'h41};
    check_seq("after_rst_up", 0, ref_q);
    check_seq("after_rst_lo", 1, ref_q);
    repeat (5) @(negedge clk);

    check_output("total_acks_up", acks[0], exp_acks);
    check_output("total_acks_lo", acks[1], exp_acks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/print_tx.md
# print_tx

Transmit-side service for the serial debug unit. Command handlers (the B, D and similar command FSMs) raise a print request carrying either a 32-bit word or a single character. This block serialises the request into ASCII bytes on a valid/ready byte stream feeding the UART transmitter, then returns a one-cycle acknowledge. It is the responder end of the `req_tx`/`type_tx`/`ack_tx` protocol used by every command handler.

## Interface
- `LOWER_HEX`, default 0: 1 emits hex digits a–f as lowercase (0x61..0x66); 0 emits uppercase (0x41..0x46).
- `TRAIL_SPACE`, default 1: 1 appends ASCII space (0x20) after the 8 hex digits of a word print.

- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `req_tx`  in  1  print request from the selected command handler
- `type_tx`  in  1  1 = print `din_tx` as 8 hex digits; 0 = print `din_tx[7:0]` as a raw byte
- `din_tx`  in  32  data to print; must be stable while `req_tx` is high
- `ack_tx`  out  1  one-cycle pulse; request fully sent
- `tx_data`  out  8  byte to the UART transmitter
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  UART transmitter accepts the byte this cycle

## Operation
- States:
  - IDLE: wait for a request.
  - SEND: present bytes on the stream.
  - ACK: pulse `ack_tx`, then return to IDLE.
- IDLE: if `req_tx`=1, latch `din_tx` into `word_q`, latch `type_tx` into `type_q`, clear `idx`, and go to SEND.
- Byte count N:
  - `type_q`=1: 9 when `TRAIL_SPACE`=1, else 8.
  - `type_q`=0: 1.
- Hex byte `idx` (0..7) is the ASCII of nibble `word_q[31-4*idx -: 4]`, most significant nibble first.
  - Nibble 0–9 maps to 0x30+n.
  - Nibble 10–15 maps to 0x41+(n-10), or 0x61+(n-10) when `LOWER_HEX`=1.
  - `idx`=8 is 0x20.
- Char mode: the single byte is `word_q[7:0]`, sent unmodified (0x0D and 0x0A pass through).
- SEND:
  - `tx_valid`=1.
  - On `tx_valid && tx_ready`: `idx` increments. When `idx` = N-1, go to ACK.
- ACK: `ack_tx`=1 for exactly one cycle. `req_tx` is ignored in this state; the requester drops it the cycle after the ack. Then IDLE.
- `req_tx` falling during SEND is ignored; the transfer completes.
- `din_tx` changes after latching are ignored.

## Timing
- Reset values: `ack_tx`=0, `tx_valid`=0, `tx_data`=0x00, state=IDLE, `idx`=0, `word_q`=0, `type_q`=0.
- Reset mid-transfer aborts immediately. No partial ack is issued, and the stream drops valid asynchronously.
- `tx_valid` and `tx_data` are registered outputs.
- `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0. The next byte appears the cycle after acceptance.
- With `req_tx` sampled high at edge t and `tx_ready` held at 1:
  - First byte is valid in cycle t+1.
  - Byte k is accepted in cycle t+1+k.
  - `ack_tx`=1 in cycle t+1+N.
  - IDLE again at t+2+N.
- Word print with defaults: 9 byte cycles, ack at t+10. Char print: ack at t+2.
- Each cycle `tx_ready`=0 while `tx_valid`=1 delays the ack by one cycle.
- Minimum request-to-request spacing: the next request is sampled in IDLE no earlier than 2 cycles after `ack_tx`. This matches a requester that clears `req_tx` on ack and re-raises it the following cycle.
- `idx` is 4 bits; no wrap occurs since N ≤ 9.

## Structure
- Shared package `dbg_pkg` holds:
  - ASCII constants: `ASCII_0`=0x30, `ASCII_A_UP`=0x41, `ASCII_A_LO`=0x61, `ASCII_SP`=0x20, `ASCII_CR`=0x0D, `ASCII_LF`=0x0A.
  - The empty-marker constant `WORD_EMPTY`=32'hFFFF_FFFF.
  - The print-state enum (IDLE/SEND/ACK).
- One combinational sub-module, `nib2ascii`: 4-bit nibble plus `LOWER_HEX` to 8-bit ASCII. The RTX receiver reuses the inverse mapping.

## Test plan
- Word print, `din_tx`=0x1234ABCD, `type_tx`=1, `tx_ready`=1 → bytes "1234ABCD " (0x31 32 33 34 41 42 43 44 20), then one `ack_tx` pulse at t+10.
- Empty marker 0xFFFFFFFF with `LOWER_HEX`=1 → "ffffffff " (0x66 ×8, 0x20), one ack.
- Char prints 0x0D then 0x0A, with requester re-raising `req_tx` one cycle after each ack → exactly two bytes 0x0D, 0x0A, two ack pulses, no duplicate byte.
- Backpressure: `tx_ready` toggling 1,0,0,1,… during a word print → each byte is held stable until accepted, order is preserved, and ack is delayed by the number of stall cycles.
- `req_tx` held high through the ack cycle → no second transfer starts from the stale request.
- `rstn` asserted after 3 bytes of a word print → `tx_valid`=0 and `ack_tx`=0 at once. After release, a new char print 0x41 emits only 0x41.
